// File: rtl/pipe_flow_ctrl_if.sv
// Pipeline flow-control bundle: hazard/MDU/exception requests in,
// stage write-enables, bubble/flush and MDU status out.
interface pipe_flow_ctrl_if;
  logic        stall_hazard;
  logic        mdu_start;
  logic        mdu_is_div;
  logic        mdu_use_D;
  logic        req;
  logic        pc_we;
  logic        d_we;
  logic        e_bubble;
  logic        e_we;
  logic        m_we;
  logic        w_we;
  logic        flush;
  logic        mdu_busy;
  logic        mdu_done;
  logic [31:0] stall_cnt;

  modport master (
    output stall_hazard,
    output mdu_start,
    output mdu_is_div,
    output mdu_use_D,
    output req,
    input  pc_we,
    input  d_we,
    input  e_bubble,
    input  e_we,
    input  m_we,
    input  w_we,
    input  flush,
    input  mdu_busy,
    input  mdu_done,
    input  stall_cnt
  );

  modport slave (
    input  stall_hazard,
    input  mdu_start,
    input  mdu_is_div,
    input  mdu_use_D,
    input  req,
    output pc_we,
    output d_we,
    output e_bubble,
    output e_we,
    output m_we,
    output w_we,
    output flush,
    output mdu_busy,
    output mdu_done,
    output stall_cnt
  );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: MDU busy timer,
// hazard/MDU stall merge, exception flush priority, stall perf counter.
module pipe_flow_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            reset,
  pipe_flow_ctrl_if.slave bus
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MDU_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [31:0]      stall_cnt_q;

  logic in_wait;
  logic cnt_last;
  logic start_ok;
  logic busy;
  logic stall;

  always_comb begin
    in_wait  = (state == MDU_WAIT);
    cnt_last = in_wait && (cnt == ONE);
    start_ok = bus.mdu_start && !bus.req && !in_wait;
    busy     = bus.mdu_start || in_wait;
    stall    = !bus.req &&
               (bus.stall_hazard || (bus.mdu_use_D && busy));
  end

  assign bus.mdu_busy  = busy;
  assign bus.mdu_done  = cnt_last;
  assign bus.stall_cnt = stall_cnt_q;

  // req wins over any stall; stall already excludes req
  always_comb begin
    bus.pc_we    = 1'b1;
    bus.d_we     = 1'b1;
    bus.e_bubble = 1'b0;
    bus.e_we     = 1'b1;
    bus.m_we     = 1'b1;
    bus.w_we     = 1'b1;
    bus.flush    = 1'b0;
    unique case (1'b1)
      bus.req: begin
        bus.flush = 1'b1;
      end
      stall: begin
        bus.pc_we    = 1'b0;
        bus.d_we     = 1'b0;
        bus.e_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // req in MDU_WAIT does not abort the running operation
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        if (start_ok) begin
          state_nxt = MDU_WAIT;
          cnt_nxt   = bus.mdu_is_div ? DIV_LD : MULT_LD;
        end
      end
      MDU_WAIT: begin
        cnt_nxt = cnt - ONE;
        if (cnt_last) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule
